// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter; a four-state handshake FSM pops one byte
// at a time and issues a single-cycle send request when the transmitter is ready.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   ovf_clear,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    input  logic                   tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
    localparam logic [CW-1:0] WAIT_LAST  = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] wait_cnt, wait_cnt_next;
    logic          push, pop;

    assign level    = count;
    assign empty    = (count == '0);
    assign wr_ready = (count != FULL_LEVEL);
    assign push     = wr_valid && wr_ready;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        pop           = 1'b0;
        tx_send       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && tx_ready) begin
                    state_next = SEND;
                    pop        = 1'b1;
                end
            end
            SEND: begin
                tx_send       = 1'b1;
                state_next    = WAIT_BUSY;
                wait_cnt_next = '0;
            end
            WAIT_BUSY: begin
                // Give up waiting for the busy acknowledge after ACK_TIMEOUT cycles.
                if (!tx_ready || wait_cnt == WAIT_LAST) begin
                    state_next = WAIT_DONE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            // A rejected write in the same cycle as a clear leaves the flag set.
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: byte-order queue, occupancy/overflow
// model and send-protocol timing checks, plus directed full, timeout and reset scenarios.
module tb_uart_tx_fifo;
    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 4;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          ovf_clear = 1'b0;
    logic          tx_ready = 1'b0;
    logic          wr_ready, empty, overflow, tx_send;
    logic [LW-1:0] level;
    logic [7:0]    tx_data;

    uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .level(level), .empty(empty), .overflow(overflow),
        .ovf_clear(ovf_clear), .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         m_count = 0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_last = '0;
    int         cyc = 0;
    int         last_send_cyc = -100;
    int         last_acc_cyc = -100;
    int         send_cyc[$];
    int         sends = 0;
    int         simult = 0;
    bit         uart_auto = 1'b0;
    bit         fixed_ready = 1'b0;
    bit         busy_rand = 1'b0;
    int         busy_max = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: FIFO occupancy is pushes minus sends; every send must carry the oldest byte.
    initial begin
        bit v, c, r, acc, popd;
        int pre;
        forever begin
            @(posedge clk);
            v = wr_valid; c = ovf_clear; r = tx_ready; pre = m_count;
            #1;
            cyc++;
            if (reset) begin
                m_count = 0; m_ovf = 1'b0; m_last = '0; last_send_cyc = -100;
                chk("rst_tx_send", int'(tx_send), 0);
                chk("rst_level", int'(level), 0);
                chk("rst_empty", int'(empty), 1);
                chk("rst_wr_ready", int'(wr_ready), 1);
                chk("rst_overflow", int'(overflow), 0);
                chk("rst_tx_data", int'(tx_data), 0);
            end else begin
                acc = v && (pre < DEPTH);
                if (acc) last_acc_cyc = cyc;
                if (v && pre == DEPTH) m_ovf = 1'b1;
                else if (c) m_ovf = 1'b0;
                popd = 1'b0;
                if (tx_send) begin
                    chk("send_nonempty", int'(pre != 0), 1);
                    chk("send_ready", int'(r), 1);
                    chk("send_spacing", int'((cyc - last_send_cyc) >= 3), 1);
                    chk("send_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) m_last = exp_q.pop_front();
                    chk("tx_data", int'(tx_data), int'(m_last));
                    popd = (pre > 0);
                    last_send_cyc = cyc;
                    send_cyc.push_back(cyc);
                    sends++;
                end else begin
                    chk("tx_data_hold", int'(tx_data), int'(m_last));
                end
                if (acc && popd) simult++;
                m_count = pre + int'(acc) - int'(popd);
                chk("level", int'(level), m_count);
                chk("empty", int'(empty), int'(m_count == 0));
                chk("wr_ready", int'(wr_ready), int'(m_count != DEPTH));
                chk("overflow", int'(overflow), int'(m_ovf));
            end
        end
    end

    // Transmitter model: either a fixed ready level or busy for a while after each send.
    initial begin
        int busy = 0;
        forever begin
            @(negedge clk);
            if (uart_auto) begin
                if (tx_send) busy = busy_rand ? int'($urandom_range(busy_max, 0)) : busy_max;
                if (busy > 0) begin
                    tx_ready = 1'b0;
                    busy--;
                end else begin
                    tx_ready = 1'b1;
                end
            end else begin
                tx_ready = fixed_ready;
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        if (m_count < DEPTH) exp_q.push_back(b);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_valid  = 1'b0;
            ovf_clear = 1'b0;
        end
    endtask

    task automatic wait_sends(input int target, input int budget);
        int i = 0;
        while (sends < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("send_wait", int'(sends >= target), 1);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || m_count != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain", int'(exp_q.size() == 0 && m_count == 0), 1);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("async_tx_send", int'(tx_send), 0);
        chk("async_level", int'(level), 0);
        chk("async_empty", int'(empty), 1);
        chk("async_wr_ready", int'(wr_ready), 1);
        chk("async_overflow", int'(overflow), 0);
        chk("async_tx_data", int'(tx_data), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n0, sz, sent, iter;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        fixed_ready = 1'b1;
        idle_cycles(3);

        // Single byte: send launched on the edge after the write edge.
        n0 = sends;
        write_byte(8'h41);
        idle_cycles(1);
        wait_sends(n0 + 1, 10);
        if (sends > n0) chk("first_latency", send_cyc[send_cyc.size()-1] - last_acc_cyc, 1);
        idle_cycles(10);
        chk("single_count", sends - n0, 1);
        chk("single_level", int'(level), 0);

        // Ordering with a transmitter busy for 10 cycles per byte.
        busy_rand = 1'b0; busy_max = 10; uart_auto = 1'b1;
        n0 = sends;
        for (int b = 1; b <= 5; b++) write_byte(8'(b));
        idle_cycles(1);
        wait_sends(n0 + 5, 200);
        sz = send_cyc.size();
        if (sends - n0 == 5)
            for (int k = 1; k < 5; k++)
                chk("order_gap", int'(send_cyc[sz-5+k] - send_cyc[sz-6+k] >= 11), 1);
        wait_drain(50);

        // Timeout: ready never drops.
        uart_auto = 1'b0; fixed_ready = 1'b1;
        idle_cycles(20);
        n0 = sends;
        for (int b = 0; b < 3; b++) write_byte(8'hA0 + 8'(b));
        idle_cycles(1);
        wait_sends(n0 + 3, 100);
        idle_cycles(15);
        chk("timeout_count", sends - n0, 3);
        sz = send_cyc.size();
        if (sends - n0 == 3)
            for (int k = 1; k < 3; k++)
                chk("timeout_gap", send_cyc[sz-3+k] - send_cyc[sz-4+k], ACK_TIMEOUT + 3);

        // Full and overflow with the transmitter stalled.
        fixed_ready = 1'b0;
        idle_cycles(3);
        n0 = sends;
        for (int i = 0; i < DEPTH + 1; i++) begin
            write_byte(8'h80 + 8'(i));
            if (i == DEPTH) begin
                chk("full_wr_ready", int'(wr_ready), 0);
                chk("full_level", int'(level), DEPTH);
            end
        end
        idle_cycles(1);
        chk("ovf_set", int'(overflow), 1);
        ovf_clear = 1'b1;
        idle_cycles(1);
        chk("ovf_cleared", int'(overflow), 0);
        write_byte(8'hEE);
        ovf_clear = 1'b1;
        idle_cycles(1);
        chk("ovf_set_wins", int'(overflow), 1);
        ovf_clear = 1'b1;
        idle_cycles(1);
        chk("ovf_cleared2", int'(overflow), 0);
        busy_rand = 1'b1; busy_max = 3; uart_auto = 1'b1;
        wait_drain(600);
        idle_cycles(10);
        chk("full_sent", sends - n0, DEPTH);

        // Random stream kept shallow so pushes coincide with pops.
        n0 = sends; sent = 0; iter = 0;
        while (sent < 40 && iter < 3000) begin
            @(negedge clk);
            iter++;
            if (m_count < 4 && $urandom_range(2, 0) != 0) begin
                wr_valid = 1'b1;
                wr_data  = 8'($urandom);
                exp_q.push_back(wr_data);
                sent++;
            end else begin
                wr_valid = 1'b0;
            end
        end
        idle_cycles(1);
        chk("stream_issued", sent, 40);
        wait_drain(600);
        idle_cycles(10);
        chk("stream_sent", sends - n0, 40);
        chk("stream_simult_seen", int'(simult > 0), 1);

        // Reset during WAIT_BUSY with five bytes queued.
        uart_auto = 1'b0; fixed_ready = 1'b1;
        idle_cycles(15);
        n0 = sends;
        for (int b = 0; b < 6; b++) write_byte(8'hC0 + 8'(b));
        @(negedge clk);
        wr_valid = 1'b0;
        chk("pre_reset_level", int'(level), 5);
        chk("pre_reset_sends", sends - n0, 1);
        pulse_reset();
        n0 = sends;
        idle_cycles(20);
        chk("no_send_after_reset", sends - n0, 0);
        write_byte(8'h5A);
        idle_cycles(1);
        wait_sends(n0 + 1, 20);
        idle_cycles(15);

        // Reset while tx_send is high.
        write_byte(8'h77);
        iter = 0;
        do begin
            @(negedge clk);
            wr_valid = 1'b0;
            iter++;
        end while (!tx_send && iter < 10);
        chk("send_seen_before_cut", int'(tx_send), 1);
        pulse_reset();
        n0 = sends;
        idle_cycles(10);
        chk("no_send_after_cut", sends - n0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
